// File: rtl/sonar_ranger.sv
// HC-SR04 ranging controller: periodic trigger, echo pulse timing in microseconds,
// timeout flagging and a power-of-two boxcar average of the readings.
module sonar_ranger #(
  parameter int TICKS_PER_US = 40,
  parameter int TRIG_US      = 20,
  parameter int PERIOD_US    = 60000,
  parameter int WIDTH        = 12,
  parameter int LOG2_DEPTH   = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             echo,
  output logic             trig,
  output logic [WIDTH-1:0] dist_us,
  output logic             dist_valid,
  output logic             timeout,
  output logic [WIDTH-1:0] avg_us,
  output logic             avg_valid
);
  localparam int TW    = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;
  localparam int PW    = (PERIOD_US > 1) ? $clog2(PERIOD_US) : 1;
  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int SW    = WIDTH + LOG2_DEPTH;
  localparam logic [WIDTH-1:0] DMAX    = '1;
  localparam logic [SW-1:0]    SUM_RST = {DMAX, {LOG2_DEPTH{1'b0}}} - SW'(DEPTH) + SW'(DEPTH);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] TRIG      = 3'd1;
  localparam logic [2:0] WAIT_ECHO = 3'd2;
  localparam logic [2:0] MEASURE   = 3'd3;
  localparam logic [2:0] HOLDOFF   = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [TW-1:0]    tick_q;
  logic [PW-1:0]    period_q, period_d;
  logic [WIDTH-1:0] pulse_q, pulse_d;
  logic             trig_q, trig_d;
  logic             echo_m_q, echo_s_q;
  logic [WIDTH-1:0] dist_q;
  logic             timeout_q, dist_valid_q;
  logic [WIDTH-1:0] avg_q;
  logic             avg_valid_q;
  logic [SW-1:0]    sum_q, sum_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [LOG2_DEPTH-1:0] wp_q;

  logic             us_tick, period_end, emit, res_to, restart;
  logic [WIDTH-1:0] res_dist;

  assign us_tick    = (tick_q == TW'(TICKS_PER_US - 1));
  assign period_end = us_tick && (period_q == PW'(PERIOD_US - 1));

  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    pulse_d  = pulse_q;
    trig_d   = trig_q;
    emit     = 1'b0;
    res_dist = DMAX;
    res_to   = 1'b0;
    restart  = 1'b0;
    if (us_tick && state_q != IDLE) period_d = period_q + 1'b1;
    case (state_q)
      IDLE: begin
        trig_d = 1'b0;
        if (enable && us_tick) begin
          state_d  = TRIG;
          period_d = '0;
          trig_d   = 1'b1;
        end
      end
      TRIG: begin
        if (us_tick && period_q == PW'(TRIG_US - 1)) begin
          state_d = WAIT_ECHO;
          trig_d  = 1'b0;
        end
      end
      WAIT_ECHO: begin
        if (period_end) begin
          emit    = 1'b1;
          res_to  = 1'b1;
          restart = 1'b1;
        end else if (echo_s_q) begin
          state_d = MEASURE;
          pulse_d = '0;
        end
      end
      MEASURE: begin
        // A normal echo end wins over a coincident period end.
        if (!echo_s_q) begin
          emit     = 1'b1;
          res_dist = pulse_q;
          if (period_end) restart = 1'b1;
          else            state_d = HOLDOFF;
        end else if (period_end) begin
          emit    = 1'b1;
          res_to  = 1'b1;
          restart = 1'b1;
        end else if (us_tick && pulse_q != DMAX) begin
          pulse_d = pulse_q + 1'b1;
        end
      end
      HOLDOFF: begin
        if (period_end) restart = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (restart) begin
      period_d = '0;
      if (enable) begin
        state_d = TRIG;
        trig_d  = 1'b1;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      tick_q       <= '0;
      period_q     <= '0;
      pulse_q      <= '0;
      trig_q       <= 1'b0;
      echo_m_q     <= 1'b0;
      echo_s_q     <= 1'b0;
      dist_q       <= DMAX;
      timeout_q    <= 1'b0;
      dist_valid_q <= 1'b0;
    end else begin
      tick_q       <= us_tick ? '0 : tick_q + 1'b1;
      echo_m_q     <= echo;
      echo_s_q     <= echo_m_q;
      state_q      <= state_d;
      period_q     <= period_d;
      pulse_q      <= pulse_d;
      trig_q       <= trig_d;
      dist_valid_q <= emit;
      if (emit) begin
        dist_q    <= res_dist;
        timeout_q <= res_to;
      end
    end
  end

  // New sum is used for both the stored sum and the average so avg follows by one clk.
  assign sum_d = sum_q - SW'(mem_q[wp_q]) + SW'(dist_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= DMAX;
      wp_q        <= '0;
      sum_q       <= SUM_RST;
      avg_q       <= DMAX;
      avg_valid_q <= 1'b0;
    end else begin
      avg_valid_q <= dist_valid_q;
      if (dist_valid_q) begin
        mem_q[wp_q] <= dist_q;
        wp_q        <= wp_q + 1'b1;
        sum_q       <= sum_d;
        avg_q       <= sum_d[SW-1:LOG2_DEPTH];
      end
    end
  end

  assign trig       = trig_q;
  assign dist_us    = dist_q;
  assign dist_valid = dist_valid_q;
  assign timeout    = timeout_q;
  assign avg_us     = avg_q;
  assign avg_valid  = avg_valid_q;
endmodule
